// File: rtl/ubus_slave_mem.sv
// ubus_slave_mem: UBUS byte memory slave; ubus_clock/ubus_reset, arbiter ubus_start, address phase (ubus_addr/size/read/write), data phase (ubus_bip, ubus_data, ubus_wait, ubus_error)
module ubus_slave_mem #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter int MEM_AW = 8,
  parameter int WAIT_STATES = 0
) (
  input logic ubus_clock,
  input logic ubus_reset,
  input logic ubus_start,
  input logic [15:0] ubus_addr,
  input logic [1:0] ubus_size,
  input logic ubus_read,
  input logic ubus_write,
  input logic ubus_bip,
  inout wire [7:0] ubus_data,
  output logic ubus_wait,
  output logic ubus_error
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
  state_t state, state_nx;
  logic is_rd;
  logic [1:0] size_q;
  logic [MEM_AW-1:0] beat_addr;
  logic [2:0] wcnt;
  logic [3:0] beats;
  logic [7:0] ram [2**MEM_AW];
  logic rd_req, wr_req, claim, beat_done, last, fault, drive;
  assign rd_req = ubus_read === 1'b1;
  assign wr_req = ubus_write === 1'b1;
  assign claim = (rd_req ^ wr_req) && ubus_addr[15:MEM_AW] == ADDR_BASE[15:MEM_AW];
  assign beat_done = state == DATA && wcnt == 3'd0;
  assign last = ubus_bip !== 1'b1;
  assign fault = &beat_addr || beats + 4'd1 == 4'd1 << size_q;
  always_comb begin
    state_nx = state == IDLE ? (ubus_start === 1'b1 ? ADDR : IDLE) :
               state == ADDR ? (claim ? DATA : IDLE) :
               state == ERR ? IDLE :
               !beat_done ? DATA : last ? IDLE : fault ? ERR : DATA;
  end
  always_ff @(posedge ubus_clock or posedge ubus_reset)
    if (ubus_reset) begin
      state <= IDLE;
      is_rd <= 1'b0;
      size_q <= 2'd0;
      beat_addr <= '0;
      wcnt <= 3'd0;
      beats <= 4'd0;
    end else begin
      state <= state_nx;
      if (state == ADDR) begin
        is_rd <= rd_req;
        size_q <= ubus_size;
        beat_addr <= ubus_addr[MEM_AW-1:0];
        wcnt <= 3'(WAIT_STATES);
        beats <= 4'd0;
      end else if (state == DATA) begin
        wcnt <= beat_done ? 3'(WAIT_STATES) : wcnt - 3'd1;
        if (beat_done) begin
          beat_addr <= beat_addr + MEM_AW'(1);
          beats <= beats + 4'd1;
        end
      end
    end
  always_ff @(posedge ubus_clock)
    if (beat_done && !is_rd) ram[beat_addr] <= ubus_data;
  assign drive = state == DATA || state == ERR;
  assign ubus_wait = drive ? state == DATA && wcnt != 3'd0 : 1'bz;
  assign ubus_error = drive ? state == ERR : 1'bz;
  assign ubus_data = state == DATA && is_rd ? ram[beat_addr] : 8'hzz;
endmodule
